// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream constants for the instruction-memory loader
package imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR   = 3'd0;
  localparam state_t ST_DATA  = 3'd1;
  localparam state_t ST_FLUSH = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_WIDTH = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - gathers four bytes into one little-endian word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic [7:0]            din,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  complete
);

  logic [1:0]  cnt;
  logic [23:0] hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      hold <= 24'd0;
    end else if (shift) begin
      cnt  <= cnt + 2'd1;
      hold <= {din, hold[23:8]};
    end
  end

  // The word is presented in the same cycle as its fourth byte, so the first byte lands in [7:0].
  assign word     = {din, hold};
  assign complete = shift && (cnt == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a counted little-endian word image into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int          IW    = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_N = MAX_WORDS;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         last_idx;
  logic                  accept;
  logic                  complete;
  logic [WORD_WIDTH-1:0] word;

  assign rx_ready = ((state == ST_HDR) || (state == ST_DATA)) && !rst;
  assign busy     = (state == ST_HDR) || (state == ST_DATA) || (state == ST_FLUSH);
  assign done     = (state == ST_DONE) && !rst;
  assign error    = (state == ST_ERR) && !rst;
  assign accept   = rx_valid && rx_ready;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .shift    (accept),
    .din      (rx_data),
    .word     (word),
    .complete (complete)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HDR;
      idx      <= '0;
      last_idx <= '0;
      we       <= 1'b0;
      waddr    <= 32'd0;
      wdata    <= 32'd0;
    end else begin
      we <= 1'b0;
      case (state)
        ST_HDR: begin
          if (complete) begin
            if (word == 32'd0) begin
              state <= ST_DONE;
            end else if (word > MAX_N) begin
              state <= ST_ERR;
            end else begin
              last_idx <= IW'(word - 32'd1);
              idx      <= '0;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (complete) begin
            we    <= 1'b1;
            waddr <= 32'(idx) << 2;
            wdata <= word;
            // The final write is still in flight during FLUSH, so done waits one more edge.
            if (idx == last_idx) begin
              state <= ST_FLUSH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_FLUSH: state <= ST_DONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

  localparam int MAXW = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, we, busy, done, error;
  logic [31:0] waddr, wdata;

  imem_loader #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_cyc = -1;
  int we_count = 0;
  bit done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe is matched against the head of the expected-write queue.
  always @(negedge clk) begin
    if (!rst && we) begin
      we_count++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_we: got addr 0x%08h data 0x%08h expected no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("we_addr", waddr, e.addr);
        chk("we_data", wdata, e.data);
      end
    end
    if (!rst && done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", waddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    we_count = 0;
    last_we_cyc = -1;
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    chk("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: rx_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    return 0;
  endfunction

  task automatic send_word(input logic [31:0] w, input int mode);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], pick_gap(mode));
  endtask

  // Reference: N==0 finishes empty, N>MAX errors with no writes, else word k goes to byte address 4k.
  task automatic run_load(input logic [31:0] n, input logic [31:0] words[$], input int mode);
    int t;
    bit ok;
    ok = (n <= 32'(MAXW));
    send_word(n, mode);
    if (ok) begin
      for (int k = 0; k < int'(n); k++) begin
        wr_t e;
        e.addr = 32'(k) * 32'd4;
        e.data = words[k];
        exp_q.push_back(e);
        send_word(words[k], mode);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    t = 0;
    while (!done && !error && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("end_done", {31'd0, done}, {31'd0, ok});
    chk("end_error", {31'd0, error}, {31'd0, !ok});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("end_queue_empty", exp_q.size(), 32'd0);
    chk("end_we_count", we_count, ok ? n : 32'd0);
    if (ok && n != 0) chk("done_after_last_we", done_cyc, last_we_cyc + 1);
  endtask

  initial begin
    logic [31:0] ws[$];
    int n;

    do_reset();

    ws = '{32'h074000EF, 32'h00100513};
    run_load(32'd2, ws, 0);

    do_reset();
    ws = '{};
    run_load(32'd0, ws, 0);

    do_reset();
    run_load(32'h0000_4001, ws, 0);

    // Bytes offered after completion must be refused without writes.
    do_reset();
    ws = '{32'h1234_5678};
    run_load(32'd1, ws, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'(i + 8'hA0);
      #1;
      chk("after_done_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("after_done_we", {31'd0, we}, 32'd0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("after_done_we_count", we_count, 32'd1);

    // Abandon a load after six data bytes, then reload.
    do_reset();
    send_word(32'd3, 0);
    exp_q.push_back('{addr: 32'd0, data: 32'hCAFE_F00D});
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("abandon_we_count", we_count, 32'd1);
    do_reset();
    ws = '{32'hDEAD_BEEF};
    run_load(32'd1, ws, 0);

    for (int r = 0; r < 16; r++) begin
      do_reset();
      ws = '{};
      if ($urandom_range(0, 7) == 0) begin
        run_load(32'(MAXW + 1) + 32'($urandom_range(0, 100000)), ws, 2);
      end else begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) ws.push_back($urandom);
        run_load(32'(n), ws, int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
